// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master.
// Accepts one command at a time on a valid/ready command port, runs the
// matching AXI4-Lite write (AW+W then B) or read (AR then R) transaction, and
// presents the result on a valid/ready response port until it is consumed.
// Every AXI VALID/READY output and every response output comes straight from
// a flop. The FSM is a state/datapath register process plus one
// combinational next-value process.
module axi_lite_master #(
  parameter int ADDR_W = 32
) (
  input  logic              M_AXI_ACLK,
  input  logic              M_AXI_ARESETN,
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_wstrb,
  // response port
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_write,
  // write address channel
  output logic [ADDR_W-1:0] M_AXI_AWADDR,
  output logic [2:0]        M_AXI_AWPROT,
  output logic              M_AXI_AWVALID,
  input  logic              M_AXI_AWREADY,
  // write data channel
  output logic [31:0]       M_AXI_WDATA,
  output logic [3:0]        M_AXI_WSTRB,
  output logic              M_AXI_WVALID,
  input  logic              M_AXI_WREADY,
  // write response channel
  input  logic [1:0]        M_AXI_BRESP,
  input  logic              M_AXI_BVALID,
  output logic              M_AXI_BREADY,
  // read address channel
  output logic [ADDR_W-1:0] M_AXI_ARADDR,
  output logic [2:0]        M_AXI_ARPROT,
  output logic              M_AXI_ARVALID,
  input  logic              M_AXI_ARREADY,
  // read data channel
  input  logic [31:0]       M_AXI_RDATA,
  input  logic [1:0]        M_AXI_RRESP,
  input  logic              M_AXI_RVALID,
  output logic              M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WREQ  = 3'd1,
    WRESP = 3'd2,
    RREQ  = 3'd3,
    RRESP = 3'd4,
    RSP   = 3'd5
  } state_t;

  // Error responses are SLVERR (2'b10) and DECERR (2'b11); bit 1 alone
  // distinguishes them from OKAY/EXOKAY.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

  state_t state_r, state_s;

  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]       wdata_r, wdata_s;
  logic [3:0]        wstrb_r, wstrb_s;
  logic              write_r, write_s;

  logic              cmd_ready_r, cmd_ready_s;
  logic              awvalid_r, awvalid_s;
  logic              wvalid_r, wvalid_s;
  logic              aw_done_r, aw_done_s;
  logic              w_done_r, w_done_s;
  logic              bready_r, bready_s;
  logic              arvalid_r, arvalid_s;
  logic              rready_r, rready_s;

  logic              rsp_valid_r, rsp_valid_s;
  logic [31:0]       rsp_rdata_r, rsp_rdata_s;
  logic              rsp_err_r, rsp_err_s;
  logic              rsp_write_r, rsp_write_s;

  // Channel handshakes. Each VALID flop is only ever high in its own state,
  // so READY (or B/R VALID) arriving at any other time has no effect.
  logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  assign aw_hs_s = awvalid_r & M_AXI_AWREADY;
  assign w_hs_s  = wvalid_r  & M_AXI_WREADY;
  assign b_hs_s  = bready_r  & M_AXI_BVALID;
  assign ar_hs_s = arvalid_r & M_AXI_ARREADY;
  assign r_hs_s  = rready_r  & M_AXI_RVALID;

  // The low response bit (EXOKAY vs OKAY) carries no information for the
  // response port; gathered here so it is visibly consumed.
  logic unused_resp_lsb_s;
  assign unused_resp_lsb_s = M_AXI_BRESP[0] ^ M_AXI_RRESP[0];

  // Next-state and next-register values; every register holds by default.
  always_comb begin
    state_s     = state_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    wstrb_s     = wstrb_r;
    write_s     = write_r;
    awvalid_s   = awvalid_r;
    wvalid_s    = wvalid_r;
    aw_done_s   = aw_done_r;
    w_done_s    = w_done_r;
    bready_s    = bready_r;
    arvalid_s   = arvalid_r;
    rready_s    = rready_r;
    rsp_valid_s = rsp_valid_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_err_s   = rsp_err_r;
    rsp_write_s = rsp_write_r;
    cmd_ready_s = 1'b0;

    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          addr_s  = cmd_addr;
          wdata_s = cmd_wdata;
          wstrb_s = cmd_wstrb;
          write_s = cmd_write;
          if (cmd_write) begin
            state_s   = WREQ;
            awvalid_s = 1'b1;
            wvalid_s  = 1'b1;
            aw_done_s = 1'b0;
            w_done_s  = 1'b0;
          end else begin
            state_s   = RREQ;
            arvalid_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end

      WREQ: begin
        // AW and W complete independently, in either order or together.
        if (aw_hs_s) begin
          awvalid_s = 1'b0;
          aw_done_s = 1'b1;
        end else begin
          awvalid_s = awvalid_r;
        end
        if (w_hs_s) begin
          wvalid_s = 1'b0;
          w_done_s = 1'b1;
        end else begin
          wvalid_s = wvalid_r;
        end
        if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
          state_s  = WRESP;
          bready_s = 1'b1;
        end else begin
          state_s = WREQ;
        end
      end

      WRESP: begin
        if (b_hs_s) begin
          bready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = 32'h0000_0000;
          rsp_err_s   = resp_is_error(M_AXI_BRESP);
          rsp_write_s = write_r;
          state_s     = RSP;
        end else begin
          state_s = WRESP;
        end
      end

      RREQ: begin
        if (ar_hs_s) begin
          arvalid_s = 1'b0;
          rready_s  = 1'b1;
          state_s   = RRESP;
        end else begin
          state_s = RREQ;
        end
      end

      RRESP: begin
        if (r_hs_s) begin
          rready_s    = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_rdata_s = M_AXI_RDATA;
          rsp_err_s   = resp_is_error(M_AXI_RRESP);
          rsp_write_s = write_r;
          state_s     = RSP;
        end else begin
          state_s = RRESP;
        end
      end

      RSP: begin
        // Response outputs are frozen until the consumer takes them.
        if (rsp_ready) begin
          rsp_valid_s = 1'b0;
          state_s     = IDLE;
        end else begin
          state_s = RSP;
        end
      end

      default: begin
        // Unreachable encodings fall back to a quiet IDLE.
        state_s     = IDLE;
        awvalid_s   = 1'b0;
        wvalid_s    = 1'b0;
        bready_s    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        rsp_valid_s = 1'b0;
      end
    endcase

    // cmd_ready is a flop tracking "the next state is IDLE".
    if (state_s == IDLE) begin
      cmd_ready_s = 1'b1;
    end else begin
      cmd_ready_s = 1'b0;
    end
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_r     <= IDLE;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= 32'h0000_0000;
      wstrb_r     <= 4'h0;
      write_r     <= 1'b0;
      cmd_ready_r <= 1'b0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_err_r   <= 1'b0;
      rsp_write_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      wstrb_r     <= wstrb_s;
      write_r     <= write_s;
      cmd_ready_r <= cmd_ready_s;
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      aw_done_r   <= aw_done_s;
      w_done_r    <= w_done_s;
      bready_r    <= bready_s;
      arvalid_r   <= arvalid_s;
      rready_r    <= rready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_err_r   <= rsp_err_s;
      rsp_write_r <= rsp_write_s;
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_rdata     = rsp_rdata_r;
  assign rsp_err       = rsp_err_r;
  assign rsp_write     = rsp_write_r;

  assign M_AXI_AWADDR  = addr_r;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_r;
  assign M_AXI_WDATA   = wdata_r;
  assign M_AXI_WSTRB   = wstrb_r;
  assign M_AXI_WVALID  = wvalid_r;
  assign M_AXI_BREADY  = bready_r;
  assign M_AXI_ARADDR  = addr_r;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_r;
  assign M_AXI_RREADY  = rready_r;

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: a table of transactions with
// hand-computed results, an AXI-Lite slave emulated from tasks, and a few
// hand-written sequences for reset and stray-handshake corners.
module tb_axi_lite_master;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              rsp_valid, rsp_ready, rsp_err, rsp_write;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready, bvalid, bready;
  logic              arvalid, arready, rvalid, rready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;

  int checks = 0;
  int errors = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_W(ADDR_W)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_write(rsp_write),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // Count completed handshakes on every AXI channel.
  always @(posedge clk) begin
    if (rst_n) begin
      if (awvalid && awready) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= w_cnt + 1;
      if (bvalid && bready)   b_cnt  <= b_cnt + 1;
      if (arvalid && arready) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready)   r_cnt  <= r_cnt + 1;
    end
  end

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    logic [1:0]  resp;
    logic [31:0] slv_rdata;
    int          rsp_dly;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic issue_cmd(input vec_t v);
    chk("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_write = v.write;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_wstrb = v.wstrb;
    @(negedge clk);
    // Scramble the command inputs to prove they were captured.
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    cmd_wdata = ~v.wdata;
    cmd_wstrb = ~v.wstrb;
    chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
  endtask

  task automatic aw_side(input vec_t v);
    for (int i = 0; i < v.aw_dly; i++) begin
      chk("awvalid_hold", {31'd0, awvalid}, 32'd1);
      chk("awaddr_stable", awaddr, v.addr);
      @(negedge clk);
    end
    chk("awvalid_hold", {31'd0, awvalid}, 32'd1);
    chk("awaddr", awaddr, v.addr);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    chk("awvalid_drop", {31'd0, awvalid}, 32'd0);
  endtask

  task automatic w_side(input vec_t v);
    for (int i = 0; i < v.w_dly; i++) begin
      chk("wvalid_hold", {31'd0, wvalid}, 32'd1);
      chk("wdata_stable", wdata, v.wdata);
      @(negedge clk);
    end
    chk("wvalid_hold", {31'd0, wvalid}, 32'd1);
    chk("wdata", wdata, v.wdata);
    chk("wstrb", {28'd0, wstrb}, {28'd0, v.wstrb});
    wready = 1'b1;
    @(negedge clk);
    wready = 1'b0;
    chk("wvalid_drop", {31'd0, wvalid}, 32'd0);
  endtask

  task automatic do_txn(input vec_t v, input string tag);
    int aw0, w0, b0, ar0, r0;
    logic exp_write;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ar0 = ar_cnt; r0 = r_cnt;
    exp_write = v.write;
    issue_cmd(v);
    if (v.write) begin
      chk("arvalid_quiet", {31'd0, arvalid}, 32'd0);
      fork
        aw_side(v);
        w_side(v);
      join
      chk("bready_up", {31'd0, bready}, 32'd1);
      @(negedge clk);
      chk("bready_wait", {31'd0, bready}, 32'd1);
      bvalid = 1'b1;
      bresp  = v.resp;
      @(negedge clk);
      bvalid = 1'b0;
      bresp  = 2'b10;
      chk("bready_drop", {31'd0, bready}, 32'd0);
    end else begin
      chk("awvalid_quiet", {31'd0, awvalid}, 32'd0);
      for (int i = 0; i < v.ar_dly; i++) begin
        chk("arvalid_hold", {31'd0, arvalid}, 32'd1);
        chk("araddr_stable", araddr, v.addr);
        @(negedge clk);
      end
      chk("araddr", araddr, v.addr);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("arvalid_drop", {31'd0, arvalid}, 32'd0);
      chk("rready_up", {31'd0, rready}, 32'd1);
      @(negedge clk);
      rvalid = 1'b1;
      rdata  = v.slv_rdata;
      rresp  = v.resp;
      @(negedge clk);
      rvalid = 1'b0;
      rdata  = 32'h0BAD_0BAD;
      rresp  = 2'b11;
      chk("rready_drop", {31'd0, rready}, 32'd0);
    end
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, v.exp_err});
    chk({tag, "_write"}, {31'd0, rsp_write}, {31'd0, exp_write});
    for (int i = 0; i < v.rsp_dly; i++) begin
      @(negedge clk);
      chk("rsp_valid_stall", {31'd0, rsp_valid}, 32'd1);
      chk("rsp_rdata_stall", rsp_rdata, v.exp_rdata);
      chk("cmd_ready_stall", {31'd0, cmd_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("cmd_ready_back", {31'd0, cmd_ready}, 32'd1);
    chk({tag, "_aw_cnt"}, aw_cnt - aw0, v.write ? 32'd1 : 32'd0);
    chk({tag, "_w_cnt"},  w_cnt - w0,   v.write ? 32'd1 : 32'd0);
    chk({tag, "_b_cnt"},  b_cnt - b0,   v.write ? 32'd1 : 32'd0);
    chk({tag, "_ar_cnt"}, ar_cnt - ar0, v.write ? 32'd0 : 32'd1);
    chk({tag, "_r_cnt"},  r_cnt - r0,   v.write ? 32'd0 : 32'd1);
  endtask

  // Watchdog: the bench never stalls, but a broken design must not hang it.
  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    //          wr    addr          wdata         strb  awd wd ard resp   slave rdata   rspd exp_rdata     err
    vecs[0] = '{1'b1, 32'h0000_0000, 32'h0000_0007, 4'hF, 0, 0, 0, 2'b00, 32'h0,        0, 32'h0,        1'b0};
    vecs[1] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 4'h3, 0, 3, 0, 2'b00, 32'h0,        0, 32'h0,        1'b0};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 2, 2'b00, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0020, 32'hA5A5_0F0F, 4'h8, 2, 0, 0, 2'b10, 32'h0,        0, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,         4'h0, 0, 0, 0, 2'b11, 32'hCAFE_F00D, 0, 32'hCAFE_F00D, 1'b1};
    vecs[5] = '{1'b1, 32'h8000_0004, 32'hFFFF_0000, 4'hC, 1, 1, 0, 2'b01, 32'h0,        0, 32'h0,        1'b0};
    vecs[6] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 0, 0, 1, 2'b01, 32'h0000_00A5, 0, 32'h0000_00A5, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0200, 32'h0,         4'h0, 0, 0, 0, 2'b00, 32'h55AA_55AA, 5, 32'h55AA_55AA, 1'b0};

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    rsp_ready = 1'b0;
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;

    // Outputs while reset is held.
    repeat (2) @(negedge clk);
    chk("rst_awvalid", {31'd0, awvalid}, 32'd0);
    chk("rst_wvalid", {31'd0, wvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_bready", {31'd0, bready}, 32'd0);
    chk("rst_rready", {31'd0, rready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp", {rsp_rdata[29:0], rsp_err, rsp_write}, 32'd0);
    chk("rst_prot", {26'd0, awprot, arprot}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // Stray READYs and B/R VALIDs while idle must be ignored.
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b1; bresp = 2'b10; rvalid = 1'b1; rresp = 2'b10;
    repeat (2) @(negedge clk);
    chk("stray_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("stray_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("stray_valids", {29'd0, awvalid, wvalid, arvalid}, 32'd0);
    chk("stray_hs", aw_cnt + w_cnt + ar_cnt, 32'd0);
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rresp = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      do_txn(vecs[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end

    // Reset in the middle of a write address phase.
    issue_cmd(vecs[1]);
    chk("mid_awvalid", {31'd0, awvalid}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_awvalid", {31'd0, awvalid}, 32'd0);
    chk("abort_wvalid", {31'd0, wvalid}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    do_txn(vecs[2], "post_rst_read");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter: ADDR_W, default 32, width of cmd_addr, M_AXI_AWADDR and M_AXI_ARADDR.
REQ-002 M_AXI_ACLK  in  1  sole clock; all state changes on its rising edge.
REQ-003 M_AXI_ARESETN  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command request.
REQ-005 cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  ADDR_W  target byte address.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 cmd_wstrb  in  4  write byte strobes.
REQ-010 rsp_valid  out  1  response available.
REQ-011 rsp_ready  in  1  response consumed when high together with rsp_valid.
REQ-012 rsp_rdata  out  32  read data; 0 for writes.
REQ-013 rsp_err  out  1  copy of bit 1 of the captured BRESP or RRESP.
REQ-014 rsp_write  out  1  echo of cmd_write for this response.
REQ-015 M_AXI_AWADDR/AWVALID out, AWREADY in; WDATA[31:0]/WSTRB[3:0]/WVALID out, WREADY in; BRESP[1:0]/BVALID in, BREADY out; ARADDR/ARVALID out, ARREADY in; RDATA[31:0]/RRESP[1:0]/RVALID in, RREADY out: AXI4-Lite master channels.
REQ-016 M_AXI_AWPROT and M_AXI_ARPROT  out  3  tied to 3'b000.

Function
REQ-017 States: IDLE, WREQ, WRESP, RREQ, RRESP, RSP; one transaction outstanding at a time.
REQ-018 cmd_ready is high only in IDLE.
REQ-019 On a command handshake, addr, wdata, wstrb and write are registered; next state is WREQ for a write and RREQ for a read.
REQ-020 All AXI VALID/READY outputs are registered, so AWVALID/WVALID or ARVALID rise in the first cycle after the command handshake.
REQ-021 WREQ: AWVALID and WVALID both assert on entry; each channel is tracked independently by aw_done and w_done flags.
REQ-022 WREQ: AWVALID deasserts in the cycle after AWREADY is sampled high; WVALID likewise after WREADY; the order of the two may be either, including the same cycle.
REQ-023 WREQ exits to WRESP when both aw_done and w_done are set; BREADY is high throughout WRESP.
REQ-024 WRESP: on BVALID&BREADY, capture rsp_err = BRESP[1] and rsp_rdata = 0, drop BREADY, go to RSP.
REQ-025 RREQ: ARVALID is held until ARREADY is sampled high, then the block enters RRESP with RREADY high.
REQ-026 RRESP: on RVALID&RREADY, capture RDATA and RRESP[1], drop RREADY, go to RSP.
REQ-027 RSP: rsp_valid high with stable outputs until rsp_ready; then IDLE, with cmd_ready high in the following cycle.
REQ-028 Once asserted, no VALID output drops before its READY handshake, and address/data stay stable while VALID is high.
REQ-029 The block applies no timeout: it waits indefinitely on every channel.
REQ-030 READY inputs asserted before the matching VALID are ignored, and B/R VALID arriving outside WRESP/RRESP is ignored.
REQ-031 A slave responding BRESP=2'b01 or RRESP=2'b01 yields rsp_err = 0.

Reset
REQ-032 While M_AXI_ARESETN is low: state IDLE; all VALID/READY outputs, rsp_valid, rsp_err, rsp_write and rsp_rdata are 0.
REQ-033 cmd_ready is 1 from the first clock edge after reset release.
REQ-034 Reset asserted mid-transaction aborts the transaction immediately, with no response produced.

Verification
REQ-035 Write 0x00 with data 0x7 and strb 0xF; slave raises AWREADY and WREADY in the same cycle; BRESP=00 -> one AW and one W handshake, then rsp_valid with rsp_err=0, rsp_write=1, rsp_rdata=0.
REQ-036 Write 0x10; slave accepts AW 3 cycles before W -> AWVALID drops after its handshake while WVALID stays high until WREADY; exactly one B handshake follows.
REQ-037 Read 0x10; ARREADY delayed 2 cycles; RDATA=0xDEADBEEF, RRESP=00 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_write=0.
REQ-038 Write with BRESP=2'b10 -> rsp_err=1; a read with RRESP=2'b11 -> rsp_err=1.
REQ-039 rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stay stable and cmd_ready stays 0; cmd_ready rises the cycle after the rsp handshake.
REQ-040 Reset asserted while in WREQ with AWVALID=1 -> AWVALID/WVALID go 0 asynchronously; after release, a new read completes normally.
